// File: rtl/axil_register_responder.sv
// AXI4-Lite responder for a bank of 32-bit control registers at BASE_ADDRESS.
// Independent write (5-state) and read (2-state) channel FSMs with registered outputs.
module axil_register_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h43C01000,
  parameter int          N_REGISTERS  = 8,
  parameter logic [31:0] RESET_VALUE  = 32'h0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                axi_awaddr,
  input  logic                       axi_awvalid,
  output logic                       axi_awready,
  input  logic [31:0]                axi_wdata,
  input  logic [3:0]                 axi_wstrb,
  input  logic                       axi_wvalid,
  output logic                       axi_wready,
  output logic [1:0]                 axi_bresp,
  output logic                       axi_bvalid,
  input  logic                       axi_bready,
  input  logic [31:0]                axi_araddr,
  input  logic                       axi_arvalid,
  output logic                       axi_arready,
  output logic [31:0]                axi_rdata,
  output logic [1:0]                 axi_rresp,
  output logic                       axi_rvalid,
  input  logic                       axi_rready,
  output logic [32*N_REGISTERS-1:0]  reg_out,
  output logic [N_REGISTERS-1:0]     write_strobe
);

  localparam int          IW    = (N_REGISTERS > 1) ? $clog2(N_REGISTERS) : 1;
  localparam logic [31:0] SPAN  = 32'(4 * N_REGISTERS);
  localparam logic [1:0]  OKAY  = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE      = 3'd0,
    W_HAVE_ADDR = 3'd1,
    W_HAVE_DATA = 3'd2,
    W_COMMIT    = 3'd3,
    W_RESP      = 3'd4
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  w_state_t                w_state_q;
  r_state_t                r_state_q;
  logic [31:0]             regs_q [N_REGISTERS];
  logic [31:0]             awaddr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic                    awready_q;
  logic                    wready_q;
  logic                    bvalid_q;
  logic [1:0]              bresp_q;
  logic [N_REGISTERS-1:0]  strobe_q;
  logic                    arready_q;
  logic                    rvalid_q;
  logic [31:0]             rdata_q;
  logic [1:0]              rresp_q;

  logic                    aw_hs;
  logic                    w_hs;
  logic                    ar_hs;
  logic [31:0]             wr_off;
  logic [31:0]             rd_off;
  logic                    wr_hit;
  logic                    rd_hit;
  logic [IW-1:0]           wr_idx;
  logic [IW-1:0]           rd_idx;
  logic [31:0]             commit_data_d;
  logic [31:0]             rdata_d;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    result = old_v;
    for (int b = 0; b < 4; b++) begin
      result[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return result;
  endfunction

  // Window decode: unsigned offset compare covers both ends; low two address bits drop out of the index.
  always_comb begin
    aw_hs         = axi_awvalid & awready_q;
    w_hs          = axi_wvalid & wready_q;
    ar_hs         = axi_arvalid & arready_q;
    wr_off        = awaddr_q - BASE_ADDRESS;
    wr_hit        = (awaddr_q >= BASE_ADDRESS) && (wr_off < SPAN);
    wr_idx        = wr_off[IW+1:2];
    rd_off        = axi_araddr - BASE_ADDRESS;
    rd_hit        = (axi_araddr >= BASE_ADDRESS) && (rd_off < SPAN);
    rd_idx        = rd_off[IW+1:2];
    commit_data_d = merge_bytes(regs_q[wr_idx], wdata_q, wstrb_q);
    rdata_d       = rd_hit ? regs_q[rd_idx] : 32'h0000_0000;
  end

  // Write channel FSM and register bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      strobe_q  <= '0;
      awaddr_q  <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'h0;
      for (int i = 0; i < N_REGISTERS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      strobe_q <= '0;
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) awaddr_q <= axi_awaddr;
          if (w_hs) begin
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
          end
          awready_q <= ~aw_hs;
          wready_q  <= ~w_hs;
          if (aw_hs && w_hs)  w_state_q <= W_COMMIT;
          else if (aw_hs)     w_state_q <= W_HAVE_ADDR;
          else if (w_hs)      w_state_q <= W_HAVE_DATA;
          else                w_state_q <= W_IDLE;
        end
        W_HAVE_ADDR: begin
          if (w_hs) begin
            wdata_q   <= axi_wdata;
            wstrb_q   <= axi_wstrb;
            wready_q  <= 1'b0;
            w_state_q <= W_COMMIT;
          end
        end
        W_HAVE_DATA: begin
          if (aw_hs) begin
            awaddr_q  <= axi_awaddr;
            awready_q <= 1'b0;
            w_state_q <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          if (wr_hit) begin
            regs_q[wr_idx]   <= commit_data_d;
            strobe_q[wr_idx] <= 1'b1;
          end
          bresp_q   <= wr_hit ? OKAY : SLVERR;
          bvalid_q  <= 1'b1;
          w_state_q <= W_RESP;
        end
        W_RESP: begin
          if (axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM; rdata samples the bank before any commit landing on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      rresp_q   <= OKAY;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= rdata_d;
            rresp_q   <= rd_hit ? OKAY : SLVERR;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b0;
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  assign axi_awready  = awready_q;
  assign axi_wready   = wready_q;
  assign axi_bvalid   = bvalid_q;
  assign axi_bresp    = bresp_q;
  assign axi_arready  = arready_q;
  assign axi_rvalid   = rvalid_q;
  assign axi_rdata    = rdata_q;
  assign axi_rresp    = rresp_q;
  assign write_strobe = strobe_q;

  for (genvar g = 0; g < N_REGISTERS; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_axil_register_responder.sv
// Bench for axil_register_responder: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized AXI-Lite traffic phase.
module tb_axil_register_responder;

  localparam logic [31:0] BASE = 32'h43C01000;
  localparam int          N    = 8;
  localparam logic [31:0] RV   = 32'h0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   axi_awaddr = 32'h0;
  logic          axi_awvalid = 1'b0;
  logic          axi_awready;
  logic [31:0]   axi_wdata = 32'h0;
  logic [3:0]    axi_wstrb = 4'h0;
  logic          axi_wvalid = 1'b0;
  logic          axi_wready;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready = 1'b0;
  logic [31:0]   axi_araddr = 32'h0;
  logic          axi_arvalid = 1'b0;
  logic          axi_arready;
  logic [31:0]   axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rvalid;
  logic          axi_rready = 1'b0;
  logic [32*N-1:0] reg_out;
  logic [N-1:0]  write_strobe;

  axil_register_responder #(.BASE_ADDRESS(BASE), .N_REGISTERS(N), .RESET_VALUE(RV)) dut (
    .clock(clock), .reset(reset),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .reg_out(reg_out), .write_strobe(write_strobe)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model (transaction view of the protocol) ----------------
  function automatic bit in_window(input logic [31:0] a);
    longint unsigned la, lb;
    la = {32'd0, a};
    lb = {32'd0, BASE};
    return (la >= lb) && (la < lb + 64'(4 * N));
  endfunction

  function automatic int win_index(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] apply_strobes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [31:0] m_regs [N];
  logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  logic [N-1:0] m_strobe;
  logic        m_have_aw, m_have_w, m_commit;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [255:0] m_flat;
  logic        m_aw_take, m_w_take, m_got_aw, m_got_w;

  assign m_aw_take = axi_awvalid && m_awready;
  assign m_w_take  = axi_wvalid && m_wready;
  assign m_got_aw  = m_have_aw || m_aw_take;
  assign m_got_w   = m_have_w || m_w_take;

  always_comb begin
    m_flat = '0;
    for (int i = 0; i < N; i++) m_flat[32*i +: 32] = m_regs[i];
  end

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) m_regs[i] <= RV;
      m_awready <= 1'b0; m_wready <= 1'b0; m_bvalid <= 1'b0; m_bresp <= 2'b00;
      m_arready <= 1'b0; m_rvalid <= 1'b0; m_rdata <= 32'h0; m_rresp <= 2'b00;
      m_strobe <= '0; m_have_aw <= 1'b0; m_have_w <= 1'b0; m_commit <= 1'b0;
      m_addr <= 32'h0; m_wdata <= 32'h0; m_wstrb <= 4'h0;
    end else begin
      m_strobe <= '0;
      if (m_commit) begin
        if (in_window(m_addr)) begin
          m_regs[win_index(m_addr)] <= apply_strobes(m_regs[win_index(m_addr)], m_wdata, m_wstrb);
          m_strobe[win_index(m_addr)] <= 1'b1;
        end
        m_bresp  <= in_window(m_addr) ? 2'b00 : 2'b10;
        m_bvalid <= 1'b1;
        m_commit <= 1'b0;
      end else if (m_bvalid) begin
        if (axi_bready) begin
          m_bvalid <= 1'b0; m_awready <= 1'b1; m_wready <= 1'b1;
        end
      end else begin
        if (m_aw_take) m_addr <= axi_awaddr;
        if (m_w_take) begin
          m_wdata <= axi_wdata; m_wstrb <= axi_wstrb;
        end
        if (m_got_aw && m_got_w) begin
          m_commit <= 1'b1; m_have_aw <= 1'b0; m_have_w <= 1'b0;
          m_awready <= 1'b0; m_wready <= 1'b0;
        end else begin
          m_have_aw <= m_got_aw; m_have_w <= m_got_w;
          m_awready <= !m_got_aw; m_wready <= !m_got_w;
        end
      end
      if (m_rvalid) begin
        if (axi_rready) begin
          m_rvalid <= 1'b0; m_arready <= 1'b1;
        end
      end else if (axi_arvalid && m_arready) begin
        m_rvalid  <= 1'b1;
        m_arready <= 1'b0;
        m_rdata   <= in_window(axi_araddr) ? m_regs[win_index(axi_araddr)] : 32'h0;
        m_rresp   <= in_window(axi_araddr) ? 2'b00 : 2'b10;
      end else begin
        m_arready <= 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      chk("m_awready", axi_awready, m_awready);
      chk("m_wready",  axi_wready,  m_wready);
      chk("m_bvalid",  axi_bvalid,  m_bvalid);
      chk("m_arready", axi_arready, m_arready);
      chk("m_rvalid",  axi_rvalid,  m_rvalid);
      chk("m_reg_out", reg_out,     m_flat);
      chk("m_strobe",  write_strobe, m_strobe);
      if (m_bvalid) chk("m_bresp", axi_bresp, m_bresp);
      if (m_rvalid) begin
        chk("m_rdata", axi_rdata, m_rdata);
        chk("m_rresp", axi_rresp, m_rresp);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [N-1:0] seen);
    bit done;
    done = 1'b0; resp = 2'b11; seen = '0;
    axi_awaddr = a; axi_awvalid = 1'b1;
    axi_wdata = d; axi_wstrb = s; axi_wvalid = 1'b1; axi_bready = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      seen = seen | write_strobe;
      if (axi_bvalid) begin
        resp = axi_bresp;
        done = 1'b1;
      end
      tick();
    end
    seen = seen | write_strobe;
    axi_bready = 1'b0;
    chk("write_done", done, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
    bit done;
    done = 1'b0; data = 32'hxxxxxxxx; resp = 2'b11;
    axi_araddr = a; axi_arvalid = 1'b1;
    tick();
    axi_arvalid = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (axi_rvalid) begin
        data = axi_rdata; resp = axi_rresp; done = 1'b1;
        axi_rready = 1'b1;
      end
      tick();
      axi_rready = 1'b0;
    end
    chk("read_done", done, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7)       return BASE + 32'(4 * $urandom_range(0, N - 1)) + 32'($urandom_range(0, 3));
    else if (r == 7) return BASE - 32'd4 + 32'($urandom_range(0, 3));
    else if (r == 8) return BASE + 32'(4 * N) + 32'($urandom_range(0, 3));
    else             return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]   resp;
    logic [N-1:0] seen;
    logic [31:0]  rd;
    logic [255:0] exp_regs;
    bit aw_hs, w_hs, ar_hs;

    tick();
    check_en = 1'b1;
    tick(); tick();
    chk("rst_awready", axi_awready, 1'b0);
    chk("rst_wready",  axi_wready,  1'b0);
    chk("rst_arready", axi_arready, 1'b0);
    reset = 1'b0;
    tick();
    chk("rel_awready", axi_awready, 1'b1);
    chk("rel_wready",  axi_wready,  1'b1);
    chk("rel_arready", axi_arready, 1'b1);
    chk("rel_bvalid",  axi_bvalid,  1'b0);
    chk("rel_rvalid",  axi_rvalid,  1'b0);
    chk("rel_regs",    reg_out,     {N{RV}});

    // Aligned write, AW and W together
    axi_awaddr = BASE + 32'd8; axi_awvalid = 1'b1;
    axi_wdata = 32'hDEADBEEF; axi_wstrb = 4'hF; axi_wvalid = 1'b1; axi_bready = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    chk("al_commit_bvalid", axi_bvalid, 1'b0);
    chk("al_commit_wready", axi_wready, 1'b0);
    tick();
    chk("al_bvalid", axi_bvalid, 1'b1);
    chk("al_bresp",  axi_bresp,  2'b00);
    chk("al_reg2",   reg_out[95:64], 32'hDEADBEEF);
    chk("al_strobe", write_strobe, 8'b0000_0100);
    tick();
    chk("al_strobe_gone", write_strobe, 8'b0000_0000);
    chk("al_bvalid_gone", axi_bvalid, 1'b0);
    axi_bready = 1'b0;

    // Split order: W first with partial strobes, AW later
    do_write(BASE, 32'hAAAAAAAA, 4'hF, resp, seen);
    axi_wdata = 32'h11223344; axi_wstrb = 4'b0101; axi_wvalid = 1'b1; axi_bready = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    chk("sp_wready0", axi_wready, 1'b0);
    chk("sp_awready", axi_awready, 1'b1);
    repeat (2) begin
      tick();
      chk("sp_wready_hold", axi_wready, 1'b0);
    end
    axi_awaddr = BASE; axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    chk("sp_commit_wready", axi_wready, 1'b0);
    tick();
    chk("sp_bvalid", axi_bvalid, 1'b1);
    chk("sp_reg0", reg_out[31:0], 32'hAA22AA44);
    chk("sp_strobe", write_strobe, 8'b0000_0001);
    chk("sp_resp_wready", axi_wready, 1'b0);
    tick();
    chk("sp_after_wready", axi_wready, 1'b1);
    chk("sp_after_awready", axi_awready, 1'b1);
    axi_bready = 1'b0;

    // Out-of-range write and read
    exp_regs = '0;
    exp_regs[31:0]  = 32'hAA22AA44;
    exp_regs[95:64] = 32'hDEADBEEF;
    do_write(BASE + 32'd32, 32'h12345678, 4'hF, resp, seen);
    chk("oor_bresp", resp, 2'b10);
    chk("oor_strobe", seen, 8'h00);
    chk("oor_regs", reg_out, exp_regs);
    do_read(BASE - 32'd4, rd, resp);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_rresp", resp, 2'b10);
    do_read(BASE + 32'd11, rd, resp);
    chk("lowbits_rdata", rd, 32'hDEADBEEF);
    chk("lowbits_rresp", resp, 2'b00);

    // Read/write collision on register 1 with read backpressure
    do_write(BASE + 32'd4, 32'h5, 4'hF, resp, seen);
    axi_awaddr = BASE + 32'd4; axi_awvalid = 1'b1;
    axi_wdata = 32'h9; axi_wstrb = 4'hF; axi_wvalid = 1'b1; axi_bready = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    axi_araddr = BASE + 32'd4; axi_arvalid = 1'b1; axi_rready = 1'b0;
    tick();
    axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("col_rvalid_hold", axi_rvalid, 1'b1);
      chk("col_rdata_hold", axi_rdata, 32'h5);
      tick();
    end
    chk("col_reg1_new", reg_out[63:32], 32'h9);
    axi_rready = 1'b1;
    chk("col_rdata_final", axi_rdata, 32'h5);
    tick();
    axi_rready = 1'b0;
    chk("col_rvalid_done", axi_rvalid, 1'b0);
    axi_bready = 1'b0;
    do_read(BASE + 32'd4, rd, resp);
    chk("col_reread", rd, 32'h9);

    // Reset while holding only a captured AW
    axi_awaddr = BASE + 32'd8; axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    chk("mid_awready", axi_awready, 1'b0);
    chk("mid_wready", axi_wready, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    axi_bready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_no_bvalid", axi_bvalid, 1'b0);
    end
    axi_bready = 1'b0;
    do_write(BASE + 32'd12, 32'h000055AA, 4'hF, resp, seen);
    chk("mid_bresp", resp, 2'b00);
    chk("mid_strobe", seen, 8'b0000_1000);
    exp_regs = '0;
    exp_regs[127:96] = 32'h000055AA;
    chk("mid_regs", reg_out, exp_regs);
    do_read(BASE + 32'd12, rd, resp);
    chk("mid_read", rd, 32'h000055AA);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      aw_hs = axi_awvalid && axi_awready;
      w_hs  = axi_wvalid && axi_wready;
      ar_hs = axi_arvalid && axi_arready;
      tick();
      if (aw_hs) axi_awvalid = 1'b0;
      if (w_hs)  axi_wvalid = 1'b0;
      if (ar_hs) axi_arvalid = 1'b0;
      if (!axi_awvalid && $urandom_range(0, 3) == 0) begin
        axi_awaddr = rand_addr(); axi_awvalid = 1'b1;
      end
      if (!axi_wvalid && $urandom_range(0, 3) == 0) begin
        axi_wdata = $urandom; axi_wstrb = 4'($urandom_range(0, 15)); axi_wvalid = 1'b1;
      end
      if (!axi_arvalid && $urandom_range(0, 2) == 0) begin
        axi_araddr = rand_addr(); axi_arvalid = 1'b1;
      end
      axi_bready = 1'($urandom_range(0, 1));
      axi_rready = 1'($urandom_range(0, 1));
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
